// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM between an instruction-fetch
// port and a data port. Arbitration is combinational in the request cycle; the
// response (read data or write ack) comes back exactly one cycle after the grant.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_req, i_addr            fetch read request and byte address
//   i_gnt, i_rvalid          fetch accepted this cycle / fetch data valid on rsp_rdata
//   d_req, d_we, d_addr      data request, write enable, byte address
//   d_wdata, d_wstrb         store data and byte enables
//   d_gnt, d_rvalid          data accepted this cycle / data read data or write ack valid
//   rsp_rdata                read data shared by both ports
//   ram_en, ram_we           RAM access and write enable
//   ram_addr                 RAM word address (byte address bits [RAM_AW+1:2])
//   ram_wdata, ram_wstrb     RAM write data and byte enables
//   ram_rdata                RAM read data, valid one cycle after a read access
//
// Build option: define RAM_ARB_FAIRNESS_EN to add a fetch starvation counter that
// forces a fetch grant after STARVE_MAX consecutive fetch denials. Without it the
// data port always wins.
module ram_arbiter #(
    parameter int unsigned RAM_AW     = 12,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_wstrb,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       rsp_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_wstrb,
    input  logic [31:0]       ram_rdata
);

    localparam logic OwnerFetch = 1'b0;
    localparam logic OwnerData  = 1'b1;

    // High when the fetch port must win a contested cycle.
    logic fetch_priority;

`ifdef RAM_ARB_FAIRNESS_EN
    localparam int unsigned CntW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CntW-1:0] starve_q, starve_d;

    assign fetch_priority = (starve_q == CntW'(STARVE_MAX));

    // Counts consecutive cycles a pending fetch was passed over; saturates.
    always_comb begin
        starve_d = starve_q;
        if (!i_req || i_gnt) begin
            starve_d = '0;
        end else if (!fetch_priority) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign fetch_priority = 1'b0;

    logic unused_starve_max;
    assign unused_starve_max = (STARVE_MAX == 0);
`endif

    // Winner selection; requests are ignored entirely while in reset.
    logic d_win, i_win;

    assign d_win = !rst && d_req && !(fetch_priority && i_req);
    assign i_win = !rst && i_req && !d_win;

    assign d_gnt = d_win;
    assign i_gnt = i_win;

    // RAM command from the winner; fetches never write.
    assign ram_en    = d_win || i_win;
    assign ram_we    = d_win && d_we;
    assign ram_wstrb = (d_win && d_we) ? d_wstrb : 4'b0000;
    assign ram_wdata = d_win ? d_wdata : 32'h0000_0000;
    assign ram_addr  = d_win ? d_addr[RAM_AW+1:2] : i_addr[RAM_AW+1:2];

    // Byte-offset and out-of-range address bits are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[31:RAM_AW+2], i_addr[1:0],
                                d_addr[31:RAM_AW+2], d_addr[1:0]};

    // Owner of the access issued last cycle; steers the one-cycle response.
    logic owner_vld_q, owner_vld_d;
    logic owner_q, owner_d;

    assign owner_vld_d = ram_en;
    assign owner_d     = d_win ? OwnerData : OwnerFetch;

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_vld_q <= 1'b0;
            owner_q     <= OwnerFetch;
        end else begin
            owner_vld_q <= owner_vld_d;
            owner_q     <= owner_d;
        end
    end

    // Gating with rst drops a response that was outstanding when reset hit.
    assign i_rvalid  = !rst && owner_vld_q && (owner_q == OwnerFetch);
    assign d_rvalid  = !rst && owner_vld_q && (owner_q == OwnerData);
    assign rsp_rdata = ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: table vectors, directed multi-cycle sequences and a
// randomized run against a memory/priority reference model.
module tb_ram_arbiter;

    localparam int unsigned RAM_AW     = 12;
    localparam int unsigned STARVE_MAX = 4;
`ifdef RAM_ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              i_req;
    logic [31:0]       i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic              d_req;
    logic              d_we;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic [3:0]        d_wstrb;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       rsp_rdata;
    logic              ram_en;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [3:0]        ram_wstrb;
    logic [31:0]       ram_rdata = 32'h0;

    always #5 clk = ~clk;

    ram_arbiter #(
        .RAM_AW    (RAM_AW),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_wstrb  (d_wstrb),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .rsp_rdata(rsp_rdata),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_wstrb(ram_wstrb),
        .ram_rdata(ram_rdata)
    );

    // Synchronous single-port RAM behind the arbiter.
    logic [31:0] ram_mem [0:(1<<RAM_AW)-1];

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_wstrb[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
                end
            end else begin
                ram_rdata <= ram_mem[ram_addr];
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    task automatic drive_idle;
        i_req   = 1'b0;
        i_addr  = 32'h0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = 32'h0;
        d_wdata = 32'h0;
        d_wstrb = 4'h0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_i_gnt"},    i_gnt,    0);
        check({tag, "_d_gnt"},    d_gnt,    0);
        check({tag, "_ram_en"},   ram_en,   0);
        check({tag, "_ram_we"},   ram_we,   0);
        check({tag, "_i_rvalid"}, i_rvalid, 0);
        check({tag, "_d_rvalid"}, d_rvalid, 0);
    endtask

    typedef struct {
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [3:0]  d_wstrb;
        logic        e_i_gnt;
        logic        e_d_gnt;
        logic        e_we;
        logic [11:0] e_addr;
        logic [3:0]  e_wstrb;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs [7];

    // Reference model state for the random run (words 0x100..0x10F only).
    logic [31:0] mdl [16];

    initial begin
        int          win, prev_win, i_wait;
        logic        prev_we, prev_i, prev_d, need_i, need_d;
        logic [31:0] prev_data;
        logic [3:0]  wi, wd;

        for (int a = 0; a < (1 << RAM_AW); a++) ram_mem[a] = 32'h0;
        ram_mem[4] = 32'h0000_0013;
        for (int a = 0; a < 16; a++) mdl[a] = 32'h0;

        //           ireq iaddr          dreq dwe daddr          dwdata         strb  ei ed we addr    strb  rdata
        vecs[0] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,       32'h0,         4'h0, 0, 0, 0, 12'h000, 4'h0, 32'h0};
        vecs[1] = '{1'b1, 32'hF000_3007, 1'b0, 1'b0, 32'h0,       32'h0,         4'h0, 1, 0, 0, 12'hC01, 4'h0, 32'h0};
        vecs[2] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h8,       32'h0,         4'hF, 0, 1, 0, 12'h002, 4'h0, 32'h0};
        vecs[3] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h4FFC,    32'hCAFE_F00D, 4'hC, 0, 1, 1, 12'h3FF, 4'hC, 32'h0};
        vecs[4] = '{1'b1, 32'h10,        1'b1, 1'b1, 32'h100,     32'h1122_3344, 4'hF, 0, 1, 1, 12'h040, 4'hF, 32'h0};
        vecs[5] = '{1'b1, 32'h10,        1'b0, 1'b1, 32'h0,       32'hFFFF_FFFF, 4'hF, 1, 0, 0, 12'h004, 4'h0, 32'h13};
        vecs[6] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,       32'h0,         4'h0, 0, 0, 0, 12'h000, 4'h0, 32'h0};

        // Reset with requests present: everything must stay quiet.
        rst = 1'b1;
        drive_idle();
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_wstrb = 4'hF;
        mid();
        check_all_zero("reset");
        tick();
        tick();
        rst = 1'b0;
        drive_idle();
        tick();

        // Fetch only: word 4 holds 0x13.
        i_req = 1'b1; i_addr = 32'h10;
        mid();
        check("fetch_i_gnt",    i_gnt,    1);
        check("fetch_d_gnt",    d_gnt,    0);
        check("fetch_ram_addr", ram_addr, 12'd4);
        check("fetch_ram_we",   ram_we,   0);
        tick();
        drive_idle();
        mid();
        check("fetch_i_rvalid", i_rvalid, 1);
        check("fetch_d_rvalid", d_rvalid, 0);
        check("fetch_rdata",    rsp_rdata, 32'h0000_0013);
        tick();

        // Partial store then read-back of word 8.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'h3;
        mid();
        check("store_d_gnt",     d_gnt,     1);
        check("store_ram_we",    ram_we,    1);
        check("store_ram_wstrb", ram_wstrb, 4'h3);
        check("store_ram_addr",  ram_addr,  12'd8);
        check("store_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
        tick();
        drive_idle();
        mid();
        check("store_d_rvalid", d_rvalid, 1);
        check("store_i_rvalid", i_rvalid, 0);
        tick();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; d_wstrb = 4'hF;
        mid();
        check("load_ram_wstrb", ram_wstrb, 4'h0);
        tick();
        drive_idle();
        mid();
        check("load_d_rvalid", d_rvalid, 1);
        check("load_rdata",    rsp_rdata, 32'h0000_BEEF);
        tick();

        // Contention for one cycle, then fetch alone: responses overlap grants.
        i_req = 1'b1; i_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        mid();
        check("both_d_gnt", d_gnt, 1);
        check("both_i_gnt", i_gnt, 0);
        tick();
        d_req = 1'b0;
        mid();
        check("both2_i_gnt",    i_gnt,    1);
        check("both2_d_rvalid", d_rvalid, 1);
        check("both2_i_rvalid", i_rvalid, 0);
        check("both2_rdata",    rsp_rdata, 32'h0000_BEEF);
        tick();
        drive_idle();
        mid();
        check("both3_i_rvalid", i_rvalid, 1);
        check("both3_d_rvalid", d_rvalid, 0);
        check("both3_rdata",    rsp_rdata, 32'h0000_0013);
        tick();

        // Reset right after a read grant drops that response.
        i_req = 1'b1; i_addr = 32'h10;
        mid();
        check("rstdrop_i_gnt", i_gnt, 1);
        tick();
        rst = 1'b1;
        d_req = 1'b1;
        mid();
        check_all_zero("rstdrop_during");
        tick();
        rst = 1'b0;
        drive_idle();
        mid();
        check("rstdrop_after_i_rvalid", i_rvalid, 0);
        check("rstdrop_after_d_rvalid", d_rvalid, 0);
        tick();

        // Both ports held high continuously.
        i_req = 1'b1; i_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        for (int k = 0; k < 10; k++) begin
            logic exp_i;
            exp_i = FAIR && ((k % (STARVE_MAX + 1)) == STARVE_MAX);
            mid();
            check($sformatf("hold%0d_i_gnt", k), i_gnt, exp_i);
            check($sformatf("hold%0d_d_gnt", k), d_gnt, !exp_i);
            tick();
        end
        drive_idle();
        tick();

        // Table vectors, one per cycle; each cycle also checks the previous response.
        prev_i = 1'b0; prev_d = 1'b0; prev_we = 1'b0; prev_data = 32'h0;
        for (int k = 0; k < 7; k++) begin
            i_req   = vecs[k].i_req;
            i_addr  = vecs[k].i_addr;
            d_req   = vecs[k].d_req;
            d_we    = vecs[k].d_we;
            d_addr  = vecs[k].d_addr;
            d_wdata = vecs[k].d_wdata;
            d_wstrb = vecs[k].d_wstrb;
            mid();
            check($sformatf("vec%0d_i_gnt", k),     i_gnt,     vecs[k].e_i_gnt);
            check($sformatf("vec%0d_d_gnt", k),     d_gnt,     vecs[k].e_d_gnt);
            check($sformatf("vec%0d_ram_en", k),    ram_en,    vecs[k].e_i_gnt | vecs[k].e_d_gnt);
            check($sformatf("vec%0d_ram_we", k),    ram_we,    vecs[k].e_we);
            check($sformatf("vec%0d_ram_wstrb", k), ram_wstrb, vecs[k].e_wstrb);
            if (vecs[k].e_i_gnt || vecs[k].e_d_gnt)
                check($sformatf("vec%0d_ram_addr", k), ram_addr, vecs[k].e_addr);
            if (vecs[k].e_we)
                check($sformatf("vec%0d_ram_wdata", k), ram_wdata, vecs[k].d_wdata);
            check($sformatf("vec%0d_prev_i_rvalid", k), i_rvalid, prev_i);
            check($sformatf("vec%0d_prev_d_rvalid", k), d_rvalid, prev_d);
            if (prev_i || (prev_d && !prev_we))
                check($sformatf("vec%0d_prev_rdata", k), rsp_rdata, prev_data);
            prev_i    = vecs[k].e_i_gnt;
            prev_d    = vecs[k].e_d_gnt;
            prev_we   = vecs[k].e_we;
            prev_data = vecs[k].e_rdata;
            tick();
        end
        drive_idle();

        // Randomized run against the reference model.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        prev_win = 0; prev_we = 1'b0; prev_data = 32'h0; i_wait = 0;
        need_i = 1'b1; need_d = 1'b1; wi = 4'h0; wd = 4'h0;
        for (int c = 0; c < 10000; c++) begin
            if (need_i) begin
                i_req  = ($urandom_range(0, 2) != 0);
                wi     = 4'($urandom_range(0, 15));
                i_addr = ($urandom & 32'hFFFF_C003) | ((32'h100 + 32'(wi)) << 2);
            end
            if (need_d) begin
                d_req   = 1'($urandom_range(0, 1));
                d_we    = 1'($urandom_range(0, 1));
                wd      = 4'($urandom_range(0, 15));
                d_addr  = ($urandom & 32'hFFFF_C003) | ((32'h100 + 32'(wd)) << 2);
                d_wdata = $urandom;
                d_wstrb = 4'($urandom_range(0, 15));
            end
            mid();
            if (d_req && !(FAIR && i_req && i_wait >= int'(STARVE_MAX))) win = 2;
            else if (i_req) win = 1;
            else win = 0;
            check("rnd_i_gnt",  i_gnt,  win == 1);
            check("rnd_d_gnt",  d_gnt,  win == 2);
            check("rnd_ram_en", ram_en, win != 0);
            if (win == 1) begin
                check("rnd_f_addr", ram_addr, 12'h100 + 12'(wi));
                check("rnd_f_we",   ram_we,   0);
            end else if (win == 2) begin
                check("rnd_d_addr",  ram_addr,  12'h100 + 12'(wd));
                check("rnd_d_we",    ram_we,    d_we);
                check("rnd_d_wstrb", ram_wstrb, d_we ? d_wstrb : 4'h0);
            end
            check("rnd_i_rvalid",   i_rvalid, prev_win == 1);
            check("rnd_d_rvalid",   d_rvalid, prev_win == 2);
            check("rnd_one_rvalid", i_rvalid && d_rvalid, 0);
            if (prev_win == 1 || (prev_win == 2 && !prev_we))
                check("rnd_rdata", rsp_rdata, prev_data);

            prev_win = win;
            prev_we  = (win == 2) && d_we;
            if (win == 1) begin
                prev_data = mdl[wi];
            end else if (win == 2 && !d_we) begin
                prev_data = mdl[wd];
            end else if (win == 2) begin
                for (int b = 0; b < 4; b++) begin
                    if (d_wstrb[b]) mdl[wd][8*b +: 8] = d_wdata[8*b +: 8];
                end
            end
            if (i_req && win != 1) i_wait = (i_wait < int'(STARVE_MAX)) ? i_wait + 1 : i_wait;
            else i_wait = 0;
            need_i = !i_req || (win == 1);
            need_d = !d_req || (win == 2);
            tick();
        end
        drive_idle();
        mid();
        check("rnd_tail_i_rvalid", i_rvalid, prev_win == 1);
        check("rnd_tail_d_rvalid", d_rvalid, prev_win == 2);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
